// File: rtl/buffer_enteros_pkg.sv
// Shared FME pixel/row constants and helpers for the integer-pixel row buffer.
// Rows pack pixel k at bits [FME_BIT_DEPTH*k +: FME_BIT_DEPTH].
package buffer_enteros_pkg;

   localparam int FME_BIT_DEPTH = 8;
   localparam int FME_WIDTH_COL = 16;
   localparam int FME_WIDTH_FIL = 16;
   localparam int FME_ROW_W     = FME_BIT_DEPTH * FME_WIDTH_COL;

   typedef logic [FME_ROW_W-1:0]     fme_row_t;
   typedef logic [FME_BIT_DEPTH-1:0] fme_pix_t;

   // Meaning of the wr pin: 0 loads a new row, 1 recirculates the chain.
   typedef enum logic {
      MODE_WRITE = 1'b0,
      MODE_READ  = 1'b1
   } fme_mode_e;

   function automatic fme_pix_t fme_pixel(input fme_row_t row, input int unsigned k);
      return row[k*FME_BIT_DEPTH +: FME_BIT_DEPTH];
   endfunction

endpackage

// File: rtl/buffer_enteros_if.sv
// Row bus of the integer-pixel buffer: load row, mode, enable and output row.
// No valid/ready: en qualifies every edge, and fila_out is always the oldest row.
interface buffer_enteros_if
   import buffer_enteros_pkg::*;
#(
   parameter int ROW_W = FME_ROW_W
) ();

   logic [ROW_W-1:0] fila_in;
   logic             wr;
   logic             en;
   logic [ROW_W-1:0] fila_out;

   modport master (output fila_in, output wr, output en, input  fila_out);
   modport slave  (input  fila_in, input  wr, input  en, output fila_out);

endinterface

// File: rtl/buffer_enteros_fila_reg.sv
// One row stage of the buffer chain: clearable, enabled register with a
// load/recirculate input mux selected by the buffer mode.
module fila_reg
   import buffer_enteros_pkg::*;
#(
   parameter int ROW_W = FME_ROW_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             wr_i,
   input  logic [ROW_W-1:0] load_i,
   input  logic [ROW_W-1:0] recirc_i,
   output logic [ROW_W-1:0] fila_o
);

   logic [ROW_W-1:0] fila_q;
   logic [ROW_W-1:0] fila_d;

   // An unknown en falls into the hold branch, so X on en never corrupts a row.
   always_comb begin
      fila_d = fila_q;
      if (en_i) begin
         if (fme_mode_e'(wr_i) == MODE_READ) fila_d = recirc_i;
         else                                 fila_d = load_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fila_q <= '0;
      else      fila_q <= fila_d;
   end

   assign fila_o = fila_q;

endmodule

// File: rtl/buffer_enteros.sv
// Integer-pixel row buffer for FME: a width_fil-deep row shift chain that loads
// one row per clock and, in read mode, rotates so the block can be re-read.
module buffer_enteros
   import buffer_enteros_pkg::*;
#(
   parameter int bit_depth = FME_BIT_DEPTH,
   parameter int width_fil = FME_WIDTH_FIL,
   parameter int width_col = FME_WIDTH_COL
) (
   input  logic             clk,
   input  logic             rst,
   buffer_enteros_if.slave  bus
);

   localparam int row_w = bit_depth * width_col;

   logic [row_w-1:0] row [width_fil];

   generate
      for (genvar g = 0; g < width_fil; g++) begin : g_fila
         if (g == 0) begin : g_head
            // The head closes the ring: new rows in write mode, the tail in read mode.
            fila_reg #(.ROW_W(row_w)) u_fila (
               .clk      (clk),
               .rst      (rst),
               .en_i     (bus.en),
               .wr_i     (bus.wr),
               .load_i   (bus.fila_in),
               .recirc_i (row[width_fil-1]),
               .fila_o   (row[g])
            );
         end else begin : g_body
            fila_reg #(.ROW_W(row_w)) u_fila (
               .clk      (clk),
               .rst      (rst),
               .en_i     (bus.en),
               .wr_i     (bus.wr),
               .load_i   (row[g-1]),
               .recirc_i (row[g-1]),
               .fila_o   (row[g])
            );
         end
      end
   endgenerate

   assign bus.fila_out = row[width_fil-1];

endmodule

// File: tb/tb_buffer_enteros.sv
// Directed bench for buffer_enteros: the driver queues the row expected on
// fila_out during each cycle; a negedge monitor pops and compares.
module tb_buffer_enteros;
   import buffer_enteros_pkg::*;

   localparam int W = FME_ROW_W;

   logic clk = 1'b0;
   logic rst;

   buffer_enteros_if #(.ROW_W(W)) bus ();

   buffer_enteros #(
      .bit_depth (FME_BIT_DEPTH),
      .width_fil (FME_WIDTH_FIL),
      .width_col (FME_WIDTH_COL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   logic [W-1:0] exp_q[$];
   bit           chk_q[$];
   string        name_q[$];
   int           checks = 0;
   int           errors = 0;

   function automatic logic [W-1:0] rep(input logic [7:0] b);
      return {FME_WIDTH_COL{b}};
   endfunction

   function automatic logic [W-1:0] rnd_row();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Apply inputs just after a rising edge; exp is the row fila_out must show
   // for the rest of this cycle (sampled at the following falling edge).
   task automatic step(input bit rst_v, input bit en_v, input bit wr_v,
                       input logic [W-1:0] din, input bit chk,
                       input logic [W-1:0] exp, input string nm);
      rst         = rst_v;
      bus.en      = en_v;
      bus.wr      = wr_v;
      bus.fila_in = din;
      chk_q.push_back(chk);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [W-1:0] e;
      bit           c;
      string        nm;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         c  = chk_q.pop_front();
         nm = name_q.pop_front();
         if (c) begin
            checks++;
            if (bus.fila_out !== e) begin
               errors++;
               $display("FAIL %s: fila_out=%h expected=%h (pix0 %h vs %h)", nm,
                        bus.fila_out, e, fme_pixel(bus.fila_out, 0), fme_pixel(e, 0));
            end
         end
      end
   end

   initial begin
      rst         = 1'b0;
      bus.en      = 1'b1;
      bus.wr      = 1'b0;
      bus.fila_in = '0;
      @(posedge clk);
      #1;

      // Reset held while writing random rows: output stays cleared.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, rnd_row(), 1'b1, '0, "reset_hold");

      // Load 0xA0..0xAF: zeros until the 16th write edge has passed.
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 1'b0, rep(8'(8'hA0 + i)), 1'b1, '0, "load_zero");

      // Read twice round the ring; first row visible before the first read edge.
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, rep(8'(8'hA0 + i)), "read");
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, rep(8'(8'hA0 + i)), "recirc");

      // Enable dropped for 3 cycles mid-read (wr toggled too): output frozen.
      step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, rep(8'hA0), "pre_hold");
      step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, rep(8'hA1), "pre_hold");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 1'(i % 2), rep(8'hEE), 1'b1, rep(8'hA2), "en_hold");
      step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, rep(8'hA2), "resume");
      step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, rep(8'hA3), "resume");

      // Reload 0x30..0x3F with a disabled write of 0xEE in the middle.
      for (int i = 0; i < 16; i++) begin
         if (i == 5) step(1'b1, 1'b0, 1'b0, rep(8'hEE), 1'b0, '0, "load_gap");
         step(1'b1, 1'b1, 1'b0, rep(8'(8'h30 + i)), 1'b0, '0, "load2");
      end
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, rep(8'(8'h30 + i)), "load_en_hold");

      // Overfill with 0x01..0x14: only the last 16 rows survive.
      for (int i = 0; i < 20; i++)
         step(1'b1, 1'b1, 1'b0, rep(8'(i + 1)), 1'b0, '0, "overfill_load");
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, rep(8'(i + 5)), "overfill_read");

      // Reset asserted between edges during a read clears the output at once.
      step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, rep(8'h05), "pre_rst");
      step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, rep(8'h06), "pre_rst");
      step(1'b0, 1'b1, 1'b1, rnd_row(), 1'b1, '0, "async_rst");
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 1'b1, rnd_row(), 1'b1, '0, "post_rst_read");

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
